// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - instruction memory port between the fetch stage and the 4K IM
interface pc_fetch_if;
  logic [29:0] im_addr;
  logic [31:0] im_dout;

  // fetch stage drives the word address and reads the returned instruction
  modport master (output im_addr, input im_dout);
  // instruction memory answers combinationally
  modport slave (input im_addr, output im_dout);
endinterface

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - PC, instruction register and next-PC logic with one delay slot
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              halt,
  input  logic [1:0]        npc_sel,
  input  logic              br_taken,
  input  logic [31:0]       rs_data,
  pc_fetch_if.master        imem,
  output logic [31:0]       pc,
  output logic [31:0]       ir,
  output logic [31:0]       ir_pc,
  output logic [31:0]       ir_pc_plus4,
  output logic              ir_valid,
  output logic              addr_err
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic        addr_err_q, addr_err_d;

  logic        load_en;
  logic        redirect_en;
  logic        halt_en;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] jr_target;
  logic [31:0] npc;

  // state register; reset lands in BOOT so the first fetch needs no redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_BOOT;
    else        state_q <= state_d;
  end

  // next state: BOOT leaves on the first unstalled edge, HALT is left only by reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  if (!stall) state_d = S_RUN;
      S_RUN:   if (halt)   state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
  end

  // control outputs: halt wins over stall, redirects only apply while running
  always_comb begin
    load_en     = 1'b0;
    redirect_en = 1'b0;
    halt_en     = 1'b0;
    case (state_q)
      S_BOOT: load_en = !stall;
      S_RUN: begin
        halt_en     = halt;
        load_en     = !halt && !stall;
        redirect_en = !halt && !stall;
      end
      default: ;
    endcase
  end

  assign pc_plus4    = pc_q + 32'd4;
  assign ir_pc_plus4 = ir_pc_q + 32'd4;
  assign br_target   = ir_pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign j_target    = {ir_pc_plus4[31:28], ir_q[25:0], 2'b00};
  assign jr_target   = {rs_data[31:2], 2'b00};

  // next-PC select for the instruction currently in IR
  always_comb begin
    npc = pc_plus4;
    case (npc_sel)
      2'b01:   if (br_taken) npc = br_target;
      2'b10:   npc = j_target;
      2'b11:   npc = jr_target;
      default: npc = pc_plus4;
    endcase
  end

  // datapath next state; the word fetched on a redirect edge is the delay slot and is kept
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    addr_err_d = addr_err_q;
    if (load_en) begin
      ir_d       = imem.im_dout;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
      pc_d       = redirect_en ? npc : pc_plus4;
    end
    if (redirect_en && (npc_sel == 2'b11) && (rs_data[1:0] != 2'b00)) addr_err_d = 1'b1;
    if (halt_en) ir_valid_d = 1'b0;
  end

  // datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      ir_q       <= 32'd0;
      ir_pc_q    <= 32'd0;
      ir_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign imem.im_addr = pc_q[31:2];
  assign pc           = pc_q;
  assign ir           = ir_q;
  assign ir_pc        = ir_pc_q;
  assign ir_valid     = ir_valid_q;
  assign addr_err     = addr_err_q;

endmodule
